multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/mc_wait_timer.sv | 37 +++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, state
// encoding, datapath select codes and the packed control-word layout.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_ERROR  = 4'd12;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       error;
    } ctrl_t;

    // States that wait on the memory handshake and are guarded by the timer.
    function automatic logic is_wait_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles in a wait state and flags the
// cycle in which one more stall would reach MEM_TIMEOUT.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic timeout_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This stalled cycle is the MEM_TIMEOUT-th one; a ready in the same cycle disables it.
    assign timeout_o = count_en_i && (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore control decode from the current state,
// with the fetch strobes gated by MemReady, and a sticky ERROR trap.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] opcode,
    input  logic       MemReady,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] State,
    output logic       Error
);

    import mips_ctrl_pkg::*;

    logic [3:0] state_q, state_d;
    logic       wait_clear, wait_en, timeout;
    ctrl_t      ctrl;

    // The branch decision is made in the datapath; Zero is carried for interface compatibility.
    logic unused_zero;
    assign unused_zero = Zero;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (MemReady)     state_d = S_DECODE;
                else if (timeout) state_d = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_ERROR;
            end
            S_MEMRD: begin
                if (MemReady)     state_d = S_MEMWB;
                else if (timeout) state_d = S_ERROR;
            end
            S_MEMWR: begin
                if (MemReady)     state_d = S_FETCH;
                else if (timeout) state_d = S_ERROR;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_ERROR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Any state change clears the counter, so every wait state is entered with zero.
    assign wait_clear = (state_d != state_q);
    assign wait_en    = is_wait_state(state_q) && !MemReady;

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (CLK),
        .rst_n     (RESET),
        .clear_i   (wait_clear),
        .count_en_i(wait_en),
        .timeout_o (timeout)
    );

    always_comb begin
        ctrl           = '0;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src_b = SRCB_REG;
        unique case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                // Only commit the fetched word and PC+4 once memory delivers, never under reset.
                ctrl.ir_write  = MemReady && RESET;
                ctrl.pc_write  = MemReady && RESET;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_ERROR:  ctrl.error     = 1'b1;
            default:  ctrl.error     = 1'b1;
        endcase
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign State       = state_q;
    assign Error       = ctrl.error;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, random instruction
// stream against a path-based reference model, and reset/timeout corner cases.
module tb_multicycle_control;

    import mips_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 15;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       MemReady = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst, Error;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] State;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .opcode(opcode), .MemReady(MemReady), .Zero(Zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .State(State), .Error(Error)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst;
        logic [1:0] pcsrc, aluop, srcb;
        logic       err;
    } exp_ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
    } vec_t;

    exp_ctrl_t act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, Error};

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Control word the datasheet table prescribes for a state.
    function automatic exp_ctrl_t exp_ctrl(input logic [3:0] st, input logic rdy, input logic rst_n);
        exp_ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:  begin c.mrd = 1'b1; c.srcb = 2'b01; c.irw = rdy & rst_n; c.pcw = rdy & rst_n; end
            S_DECODE: c.srcb = 2'b11;
            S_MEMADR: begin c.srca = 1'b1; c.srcb = 2'b10; end
            S_MEMRD:  begin c.mrd = 1'b1; c.iord = 1'b1; end
            S_MEMWB:  begin c.m2r = 1'b1; c.rw = 1'b1; end
            S_MEMWR:  begin c.mwr = 1'b1; c.iord = 1'b1; end
            S_EXEC:   begin c.srca = 1'b1; c.aluop = 2'b10; end
            S_RWB:    begin c.rdst = 1'b1; c.rw = 1'b1; end
            S_BRANCH: begin c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
            S_JUMP:   begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            S_ADDIEX: begin c.srca = 1'b1; c.srcb = 2'b10; end
            S_ADDIWB: c.rw = 1'b1;
            default:  c.err = 1'b1;
        endcase
        return c;
    endfunction

    // Called at a falling edge: drive, sample mid-low-phase, advance to next falling edge.
    task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] exp_st, input string tag);
        opcode   = op;
        MemReady = rdy;
        #2;
        check({tag, "/state"}, 32'(State), 32'(exp_st));
        check({tag, "/ctrl"}, 32'(act), 32'(exp_ctrl(exp_st, rdy, 1'b1)));
        @(negedge CLK);
    endtask

    task automatic apply_reset(input string tag);
        RESET    = 1'b0;
        MemReady = 1'b1;
        opcode   = 6'($urandom);
        #2;
        check({tag, "/rst_state"}, 32'(State), 32'(S_FETCH));
        check({tag, "/rst_ctrl"}, 32'(act), 32'(exp_ctrl(S_FETCH, 1'b1, 1'b0)));
        @(negedge CLK);
        #2;
        check({tag, "/rst_hold"}, 32'(State), 32'(S_FETCH));
        check({tag, "/rst_hold_ctrl"}, 32'(act), 32'(exp_ctrl(S_FETCH, 1'b1, 1'b0)));
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic add_vec(input logic [5:0] op, input logic rdy, input logic [3:0] st);
        vec_t v;
        v.op  = op;
        v.rdy = rdy;
        v.st  = st;
        vecs.push_back(v);
    endtask

    // Reference model: the state path of one instruction, with each wait state
    // repeated once per stalled cycle before the cycle that completes it.
    task automatic run_instr(input logic [5:0] op, input int waits, input string tag);
        logic [3:0] path[$];
        logic [3:0] st;
        logic [5:0] op_here;
        int         k;
        path.push_back(S_FETCH);
        path.push_back(S_DECODE);
        case (op)
            OP_R:    begin path.push_back(S_EXEC);   path.push_back(S_RWB);    end
            OP_LW:   begin path.push_back(S_MEMADR); path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
            OP_SW:   begin path.push_back(S_MEMADR); path.push_back(S_MEMWR);  end
            OP_BEQ:  path.push_back(S_BRANCH);
            OP_J:    path.push_back(S_JUMP);
            OP_ADDI: begin path.push_back(S_ADDIEX); path.push_back(S_ADDIWB); end
            default: path.push_back(S_ERROR);
        endcase
        foreach (path[i]) begin
            st      = path[i];
            op_here = (st == S_DECODE || st == S_MEMADR) ? op : 6'($urandom);
            if (st == S_FETCH || st == S_MEMRD || st == S_MEMWR) begin
                k = (waits < 0) ? int'($urandom_range(0, 4)) : waits;
                repeat (k) step(6'($urandom), 1'b0, st, tag);
                step(op_here, 1'b1, st, tag);
            end else begin
                step(op_here, 1'($urandom_range(0, 1)), st, tag);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops[6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

        // Latency table with MemReady=1; opcode 63 outside DECODE/MEMADR must be ignored.
        add_vec(6'd63, 1'b1, S_FETCH); add_vec(6'd0, 1'b1, S_DECODE);
        add_vec(6'd63, 1'b1, S_EXEC);  add_vec(6'd63, 1'b1, S_RWB);
        add_vec(6'd63, 1'b1, S_FETCH); add_vec(6'd35, 1'b1, S_DECODE);
        add_vec(6'd35, 1'b1, S_MEMADR); add_vec(6'd63, 1'b1, S_MEMRD);
        add_vec(6'd63, 1'b1, S_MEMWB);
        add_vec(6'd63, 1'b1, S_FETCH); add_vec(6'd43, 1'b1, S_DECODE);
        add_vec(6'd43, 1'b1, S_MEMADR); add_vec(6'd63, 1'b1, S_MEMWR);
        add_vec(6'd63, 1'b1, S_FETCH); add_vec(6'd4, 1'b1, S_DECODE);
        add_vec(6'd63, 1'b1, S_BRANCH);
        add_vec(6'd63, 1'b1, S_FETCH); add_vec(6'd2, 1'b1, S_DECODE);
        add_vec(6'd63, 1'b1, S_JUMP);
        add_vec(6'd63, 1'b1, S_FETCH); add_vec(6'd8, 1'b1, S_DECODE);
        add_vec(6'd63, 1'b1, S_ADDIEX); add_vec(6'd63, 1'b1, S_ADDIWB);
        add_vec(6'd63, 1'b0, S_FETCH);

        @(negedge CLK);
        apply_reset("init");

        foreach (vecs[i]) step(vecs[i].op, vecs[i].rdy, vecs[i].st, $sformatf("vec%0d", i));

        repeat (60) run_instr(ops[$urandom_range(0, 5)], -1, "rnd");

        // sw with three stalled MEMWR cycles: MemWrite held for four cycles.
        run_instr(OP_SW, 3, "sw_wait");
        run_instr(OP_BEQ, 0, "after_sw");

        // Illegal opcode traps and stays trapped until reset.
        run_instr(6'd63, 0, "illegal");
        repeat (10) step(6'($urandom), 1'($urandom_range(0, 1)), S_ERROR, "err_hold");
        apply_reset("err_rst");

        // Fetch timeout: 15 stalled cycles trap.
        repeat (15) step(6'($urandom), 1'b0, S_FETCH, "to_fetch");
        step(6'($urandom), 1'b0, S_ERROR, "to_err");
        apply_reset("to_rst");

        // Ready on the 15th cycle wins; counter restarts in MEMRD and the next FETCH.
        repeat (14) step(6'($urandom), 1'b0, S_FETCH, "to_edge");
        step(6'($urandom), 1'b1, S_FETCH, "to_edge_rdy");
        step(OP_LW, 1'b1, S_DECODE, "to_dec");
        step(OP_LW, 1'b1, S_MEMADR, "to_adr");
        repeat (14) step(6'($urandom), 1'b0, S_MEMRD, "rd_wait");
        step(6'($urandom), 1'b1, S_MEMRD, "rd_rdy");
        step(6'($urandom), 1'b1, S_MEMWB, "rd_wb");
        repeat (14) step(6'($urandom), 1'b0, S_FETCH, "f2_wait");
        step(6'($urandom), 1'b1, S_FETCH, "f2_rdy");
        step(OP_LW, 1'b1, S_DECODE, "f2_dec");
        step(OP_LW, 1'b1, S_MEMADR, "f2_adr");
        repeat (15) step(6'($urandom), 1'b0, S_MEMRD, "rd_to");
        step(6'($urandom), 1'b0, S_ERROR, "rd_to_err");
        apply_reset("rd_rst");

        // Asynchronous reset between edges while a write is in progress.
        step(6'($urandom), 1'b1, S_FETCH, "aw_f");
        step(OP_SW, 1'b1, S_DECODE, "aw_d");
        step(OP_SW, 1'b1, S_MEMADR, "aw_a");
        step(6'($urandom), 1'b0, S_MEMWR, "aw_w");
        MemReady = 1'b0;
        #2;
        check("aw_pre_memwrite", 32'(MemWrite), 32'd1);
        RESET = 1'b0;
        #1;
        check("aw_async_state", 32'(State), 32'(S_FETCH));
        check("aw_async_ctrl", 32'(act), 32'(exp_ctrl(S_FETCH, 1'b0, 1'b0)));
        MemReady = 1'b1;
        #1;
        check("aw_async_irwrite", 32'(act), 32'(exp_ctrl(S_FETCH, 1'b1, 1'b0)));
        @(negedge CLK);
        RESET = 1'b1;
        run_instr(OP_ADDI, 1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
